wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the pipelined MIPS core: a M/W pipeline register plus the writeback datapath that drives the register file's single write port (write enable, destination, write data, PC for the retire trace). Captures the memory-stage result each cycle and extracts and extends sub-word load data from the data-memory read word. Selects the final write value and keeps a retired-instruction counter. Sits between the memory stage / data memory and the register file.

## Interface
- No parameters; reset PC value is constant `WB_RESET_PC` = 32'h0000_3000 (shared package).
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- m_valid  in  1  memory stage holds a real instruction
- m_pc  in  32  instruction PC
- m_alu_res  in  32  ALU result / effective address
- m_hilo  in  32  HI/LO value for mfhi/mflo
- m_rd  in  5  destination register
- m_we  in  1  instruction writes a register
- m_wsel  in  2  write source: 0 ALU, 1 load, 2 PC+8, 3 HI/LO
- m_ld_type  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5–7 treated as lw
- dm_rdata  in  32  data-memory read word, valid combinationally during W (synchronous memory read issued in M)
- w_stall  in  1  hold W register
- w_flush  in  1  insert bubble into W
- rf_we  out  1  register-file write enable
- rf_a3  out  5  write address
- rf_wdata  out  32  write data
- rf_pc  out  32  PC of the writing instruction (trace)
- w_valid  out  1  W holds a real instruction
- retire_cnt  out  32  retired-instruction count

## Operation
- W register fields: valid, pc, alu_res, hilo, rd, we, wsel, ld_type.
  - Loaded from m_* on every clk rising edge unless stall/flush applies.
- Priority per edge:
  - reset: all fields cleared, pc = WB_RESET_PC.
  - else w_flush: valid=0, we=0, rd=0; other fields don't-care, cleared to 0.
  - else w_stall: hold all fields.
  - else: load.
- Load extraction, keyed on registered alu_res[1:0]:
  - lb/lbu: byte lane = alu_res[1:0]; lane 0 = bits 7:0, little-endian.
  - lh/lhu: half = alu_res[1] ? bits 31:16 : 15:0; alu_res[0] ignored (alignment faults handled upstream).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Write data mux:
  - wsel 0 → alu_res
  - wsel 1 → extracted load
  - wsel 2 → pc + 8, modulo 2^32
  - wsel 3 → hilo
- Write port outputs:
  - rf_we = valid & we & (rd != 0)
  - rf_a3 = valid ? rd : 0
  - rf_pc = pc
  - rf_wdata = mux output, regardless of rf_we
- retire_cnt increments by 1 on each edge where valid=1 and w_stall=0.
  - Wraps 32'hFFFF_FFFF → 0.
  - A flushed or bubble slot does not count.

## Timing
- One-cycle latency: m_* sampled at edge N appear on rf_* during cycle N+1.
- rf_wdata for loads is combinational from dm_rdata within the W cycle, with no extra register.
- The register file writes at the edge ending the W cycle; same-cycle read bypass is the register file's job.
- Reset values: rf_we=0, rf_a3=0, rf_wdata=0, rf_pc=32'h0000_3000, w_valid=0, retire_cnt=0.
  - rf_wdata=0 holds because the reset state is wsel=0, alu_res=0.
- Reset asserted mid-instruction: outputs drop to reset values immediately (asynchronous), with no write that cycle.
- Simultaneous w_stall and w_flush: flush wins, so the slot becomes a bubble.
- Stall held for multiple cycles:
  - rf_we stays asserted with identical data; a repeated write of the same value is harmless.
  - retire_cnt does not advance until the stall releases.

## Structure
- Shared package `wb_pkg`:
  - wsel encodings WSEL_ALU/LOAD/PC8/HILO
  - ld_type encodings LD_W/B/BU/H/HU
  - WB_RESET_PC
- Sub-module `load_ext`: purely combinational (dm_rdata, addr[1:0], ld_type) → 32-bit extended value, reusable by a future cache path.
- Top module contains only the W register, the mux, and the counter.

## Test plan
- Reset: reset=0 → rf_we=0, rf_pc=32'h3000, retire_cnt=0; release, single addu (rd=5, alu_res=32'h1234) → next cycle rf_we=1, rf_a3=5, rf_wdata=32'h1234, retire_cnt=1 after that edge.
- Loads with dm_rdata=32'h80F1_7F82:
  - lb addr …01 → 32'h0000_007F
  - lb addr …00 → 32'hFFFF_FF82
  - lbu addr …11 → 32'h0000_0080
  - lh addr …10 → 32'hFFFF_80F1
  - lhu addr …00 → 32'h0000_7F82
  - lw → unchanged
- jal at pc=32'h3010, wsel=2, rd=31 → rf_wdata=32'h3018.
  - Write to rd=0 with we=1 → rf_we=0, retire_cnt still increments.
- Stall 3 cycles with new m_* presented → rf_* unchanged, retire_cnt frozen; flush+stall together → w_valid=0, rf_we=0 next cycle.
- Counter preloaded near wrap via forced state 32'hFFFF_FFFF, one valid retire → retire_cnt=0.
- Assert reset between edges during a load → rf_we falls immediately, no write logged.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings, reset PC and W-register layout for the writeback stage
package wb_pkg;
    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_LOAD = 2'd1;
    localparam logic [1:0] WSEL_PC8  = 2'd2;
    localparam logic [1:0] WSEL_HILO = 2'd3;
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
    localparam logic [31:0] WB_RESET_PC = 32'h0000_3000;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] hilo;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wsel;
        logic [2:0]  ld_type;
    } w_reg_t;
endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: little-endian sub-word extraction and sign/zero extension of a load word
module load_ext
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    always_comb begin
        data = ld_type == LD_B  ? {{24{b[7]}}, b}  :
               ld_type == LD_BU ? {24'd0, b}       :
               ld_type == LD_H  ? {{16{h[15]}}, h} :
               ld_type == LD_HU ? {16'd0, h}       : rdata;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register, writeback mux and retired-instruction counter
module wb_stage
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_alu_res,
    input  logic [31:0] m_hilo,
    input  logic [4:0]  m_rd,
    input  logic        m_we,
    input  logic [1:0]  m_wsel,
    input  logic [2:0]  m_ld_type,
    input  logic [31:0] dm_rdata,
    input  logic        w_stall,
    input  logic        w_flush,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wdata,
    output logic [31:0] rf_pc,
    output logic        w_valid,
    output logic [31:0] retire_cnt
);
    w_reg_t      w;
    logic [31:0] ld_data;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w    <= '0;
            w.pc <= WB_RESET_PC;
        end else if (w_flush) begin
            w <= '0;
        end else if (!w_stall) begin
            w <= '{valid: m_valid, pc: m_pc, alu_res: m_alu_res, hilo: m_hilo,
                   rd: m_rd, we: m_we, wsel: m_wsel, ld_type: m_ld_type};
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retire_cnt <= '0;
        else if (w.valid && !w_stall) retire_cnt <= retire_cnt + 32'd1;
    end
    load_ext u_load_ext (
        .rdata   (dm_rdata),
        .addr    (w.alu_res[1:0]),
        .ld_type (w.ld_type),
        .data    (ld_data)
    );
    always_comb begin
        rf_wdata = w.wsel == WSEL_ALU  ? w.alu_res :
                   w.wsel == WSEL_LOAD ? ld_data   :
                   w.wsel == WSEL_PC8  ? w.pc + 32'd8 : w.hilo;
    end
    assign rf_we   = w.valid & w.we & (w.rd != 5'd0);
    assign rf_a3   = w.valid ? w.rd : 5'd0;
    assign rf_pc   = w.pc;
    assign w_valid = w.valid;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven and directed checks of the writeback stage
module tb_wb_stage;
    logic        clk = 0;
    logic        reset;
    logic        m_valid, m_we, w_stall, w_flush;
    logic [31:0] m_pc, m_alu_res, m_hilo, dm_rdata;
    logic [4:0]  m_rd;
    logic [1:0]  m_wsel;
    logic [2:0]  m_ld_type;
    logic        rf_we, w_valid;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wdata, rf_pc, retire_cnt;
    int checks = 0, failures = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_alu_res(m_alu_res),
        .m_hilo(m_hilo), .m_rd(m_rd), .m_we(m_we), .m_wsel(m_wsel), .m_ld_type(m_ld_type),
        .dm_rdata(dm_rdata), .w_stall(w_stall), .w_flush(w_flush), .rf_we(rf_we),
        .rf_a3(rf_a3), .rf_wdata(rf_wdata), .rf_pc(rf_pc), .w_valid(w_valid),
        .retire_cnt(retire_cnt)
    );

    typedef struct {
        logic [31:0] pc, alu, hilo, dm;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wsel;
        logic [2:0]  ld;
        logic        ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd;
    } vec_t;
    vec_t v[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] hilo, input logic [4:0] rd, input logic we,
                         input logic [1:0] wsel, input logic [2:0] ld);
        m_valid = valid; m_pc = pc; m_alu_res = alu; m_hilo = hilo;
        m_rd = rd; m_we = we; m_wsel = wsel; m_ld_type = ld;
    endtask

    initial begin
        v[0]  = '{32'h3000, 32'h1001, 32'h0, 32'h80F1_7F82, 5'd8,  1'b1, 2'd1, 3'd1, 1'b1, 5'd8,  32'h0000_007F};
        v[1]  = '{32'h3004, 32'h1000, 32'h0, 32'h80F1_7F82, 5'd8,  1'b1, 2'd1, 3'd1, 1'b1, 5'd8,  32'hFFFF_FF82};
        v[2]  = '{32'h3008, 32'h1003, 32'h0, 32'h80F1_7F82, 5'd9,  1'b1, 2'd1, 3'd2, 1'b1, 5'd9,  32'h0000_0080};
        v[3]  = '{32'h300C, 32'h1002, 32'h0, 32'h80F1_7F82, 5'd10, 1'b1, 2'd1, 3'd3, 1'b1, 5'd10, 32'hFFFF_80F1};
        v[4]  = '{32'h3010, 32'h1000, 32'h0, 32'h80F1_7F82, 5'd11, 1'b1, 2'd1, 3'd4, 1'b1, 5'd11, 32'h0000_7F82};
        v[5]  = '{32'h3014, 32'h1000, 32'h0, 32'h80F1_7F82, 5'd12, 1'b1, 2'd1, 3'd0, 1'b1, 5'd12, 32'h80F1_7F82};
        v[6]  = '{32'h3018, 32'h1001, 32'h0, 32'h80F1_7F82, 5'd13, 1'b1, 2'd1, 3'd6, 1'b1, 5'd13, 32'h80F1_7F82};
        v[7]  = '{32'h301C, 32'h1003, 32'h0, 32'h80F1_7F82, 5'd14, 1'b1, 2'd1, 3'd4, 1'b1, 5'd14, 32'h0000_80F1};
        v[8]  = '{32'h3010, 32'h5555, 32'h0, 32'h0,         5'd31, 1'b1, 2'd2, 3'd0, 1'b1, 5'd31, 32'h0000_3018};
        v[9]  = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0,       5'd31, 1'b1, 2'd2, 3'd0, 1'b1, 5'd31, 32'h0000_0004};
        v[10] = '{32'h3020, 32'h77, 32'hDEAD_BEEF, 32'h0,   5'd2,  1'b1, 2'd3, 3'd0, 1'b1, 5'd2,  32'hDEAD_BEEF};
        v[11] = '{32'h3024, 32'h4242, 32'h0, 32'h0,         5'd0,  1'b1, 2'd0, 3'd0, 1'b0, 5'd0,  32'h0000_4242};
        v[12] = '{32'h3028, 32'h9999, 32'h0, 32'h0,         5'd7,  1'b0, 2'd0, 3'd0, 1'b0, 5'd7,  32'h0000_9999};
        v[13] = '{32'h302C, 32'h1234_5671, 32'h0, 32'hFFFF_FFFF, 5'd3, 1'b1, 2'd0, 3'd1, 1'b1, 5'd3, 32'h1234_5671};

        reset = 0; w_stall = 0; w_flush = 0; dm_rdata = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset rf_we", {31'd0, rf_we}, 0);
        check("reset rf_a3", {27'd0, rf_a3}, 0);
        check("reset rf_wdata", rf_wdata, 0);
        check("reset rf_pc", rf_pc, 32'h3000);
        check("reset w_valid", {31'd0, w_valid}, 0);
        check("reset retire_cnt", retire_cnt, 0);
        reset = 1;
        drive(1, 32'h3000, 32'h1234, 0, 5'd5, 1, 2'd0, 3'd0);
        @(negedge clk);
        check("addu rf_we", {31'd0, rf_we}, 1);
        check("addu rf_a3", {27'd0, rf_a3}, 5);
        check("addu rf_wdata", rf_wdata, 32'h1234);
        check("addu retire_cnt", retire_cnt, 0);
        exp_cnt = 1;

        for (int i = 0; i < 14; i++) begin
            drive(1, v[i].pc, v[i].alu, v[i].hilo, v[i].rd, v[i].we, v[i].wsel, v[i].ld);
            dm_rdata = v[i].dm;
            @(negedge clk);
            check($sformatf("vec%0d rf_we", i), {31'd0, rf_we}, {31'd0, v[i].ewe});
            check($sformatf("vec%0d rf_a3", i), {27'd0, rf_a3}, {27'd0, v[i].ea3});
            check($sformatf("vec%0d rf_wdata", i), rf_wdata, v[i].ewd);
            check($sformatf("vec%0d rf_pc", i), rf_pc, v[i].pc);
            check($sformatf("vec%0d retire_cnt", i), retire_cnt, exp_cnt);
            exp_cnt++;
        end

        // stall three cycles while a new instruction waits in M
        drive(1, 32'h3100, 32'hAAAA, 0, 5'd9, 1, 2'd0, 3'd0);
        @(negedge clk);
        check("stallA rf_a3", {27'd0, rf_a3}, 9);
        check("stallA retire_cnt", retire_cnt, exp_cnt);
        w_stall = 1;
        drive(1, 32'h3104, 32'hBBBB, 0, 5'd10, 1, 2'd0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d rf_we", k), {31'd0, rf_we}, 1);
            check($sformatf("stall%0d rf_a3", k), {27'd0, rf_a3}, 9);
            check($sformatf("stall%0d rf_wdata", k), rf_wdata, 32'hAAAA);
            check($sformatf("stall%0d rf_pc", k), rf_pc, 32'h3100);
            check($sformatf("stall%0d retire_cnt", k), retire_cnt, exp_cnt);
        end
        w_stall = 0;
        @(negedge clk);
        exp_cnt++;
        check("stallB rf_a3", {27'd0, rf_a3}, 10);
        check("stallB rf_wdata", rf_wdata, 32'hBBBB);
        check("stallB retire_cnt", retire_cnt, exp_cnt);

        w_stall = 1; w_flush = 1;
        drive(1, 32'h3108, 32'hCCCC, 0, 5'd11, 1, 2'd0, 3'd0);
        @(negedge clk);
        check("flush w_valid", {31'd0, w_valid}, 0);
        check("flush rf_we", {31'd0, rf_we}, 0);
        check("flush rf_a3", {27'd0, rf_a3}, 0);
        check("flush retire_cnt", retire_cnt, exp_cnt);
        w_stall = 0; w_flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("bubble retire_cnt", retire_cnt, exp_cnt);

        // counter wrap from a forced near-wrap value
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        drive(1, 32'h3200, 32'h1, 0, 5'd6, 1, 2'd0, 3'd0);
        @(negedge clk);
        check("wrap preload", retire_cnt, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wrap retire_cnt", retire_cnt, 0);

        // asynchronous reset in the middle of a load's W cycle
        drive(1, 32'h3300, 32'h1001, 0, 5'd4, 1, 2'd1, 3'd1);
        dm_rdata = 32'h80F1_7F82;
        @(negedge clk);
        check("preload rf_we", {31'd0, rf_we}, 1);
        check("preload rf_wdata", rf_wdata, 32'h7F);
        #2 reset = 0;
        #1;
        check("async rf_we", {31'd0, rf_we}, 0);
        check("async rf_a3", {27'd0, rf_a3}, 0);
        check("async rf_wdata", rf_wdata, 0);
        check("async rf_pc", rf_pc, 32'h3000);
        check("async w_valid", {31'd0, w_valid}, 0);
        check("async retire_cnt", retire_cnt, 0);
        @(posedge clk);
        #1;
        check("inreset rf_we", {31'd0, rf_we}, 0);
        check("inreset retire_cnt", retire_cnt, 0);
        @(negedge clk);
        reset = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
